// File: rtl/speck_pkg.sv
// Shared definitions for the SPECK datapath blocks: operation modes,
// fold FSM states and a width-generic left-rotate helper.
package speck_pkg;

    typedef enum logic [1:0] {
        MODE_XOR    = 2'd0,
        MODE_ROLXOR = 2'd1,
        MODE_FOLD   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // Widest word any SPECK variant uses; rol operates on this container.
    localparam int unsigned MAX_W = 64;

    // Rotate the low 'width' bits of 'word' left by 'amount' (amount < width).
    // Bits above 'width' are returned as zero.
    function automatic logic [MAX_W-1:0] rol(input logic [MAX_W-1:0] word,
                                             input int unsigned      amount,
                                             input int unsigned      width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] w;
        logic [MAX_W-1:0] r;
        mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
        w    = word & mask;
        if (amount == 0) begin
            r = w;
        end else begin
            r = (w << amount) | (w >> (width - amount));
        end
        return r & mask;
    endfunction

endpackage

// File: rtl/xor_mode_datapath.sv
// Combinational beat function: plain XOR, or rotate-left of in1 then XOR.
module xor_mode_datapath
    import speck_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ROT   = 2
) (
    input  mode_e             mode,
    input  logic [WIDTH-1:0]  in0,
    input  logic [WIDTH-1:0]  in1,
    output logic [WIDTH-1:0]  f
);

    logic [MAX_W-1:0] in1_ext;

    // Select the beat function; every mode except ROLXOR is a plain XOR.
    always_comb begin
        in1_ext            = '0;
        in1_ext[WIDTH-1:0] = in1;
        if (mode == MODE_ROLXOR) begin
            f = in0 ^ WIDTH'(rol(in1_ext, ROT, WIDTH));
        end else begin
            f = in0 ^ in1;
        end
    end

endmodule

// File: rtl/speck_xor_unit.sv
// Handshaked XOR engine: single-beat XOR / ROLXOR results and multi-beat
// XOR folding, with a one-deep registered output stage.
module speck_xor_unit
    import speck_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ROT   = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in0,
    input  logic [WIDTH-1:0]  in1,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count
);

    if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
        $error("speck_xor_unit: WIDTH must be in 2..64");
    end
    if (ROT >= WIDTH) begin : g_bad_rot
        $error("speck_xor_unit: ROT must be below WIDTH");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("speck_xor_unit: CNT_W must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;

    mode_e             mode_eff;
    logic [WIDTH-1:0]  f;
    logic              accept;
    logic              take;
    logic [WIDTH-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_next;

    // A fold in progress forces FOLD semantics regardless of the beat's mode.
    always_comb begin
        mode_eff = (state_q == ST_ACC) ? MODE_FOLD : mode_e'(mode);
    end

    xor_mode_datapath #(
        .WIDTH (WIDTH),
        .ROT   (ROT)
    ) u_datapath (
        .mode (mode_eff),
        .in0  (in0),
        .in1  (in1),
        .f    (f)
    );

    // The output slot can refill whenever it is empty or being drained.
    always_comb begin
        in_ready = ~out_valid_q | out_ready;
        accept   = in_valid & in_ready;
        take     = out_valid_q & out_ready;
    end

    // Next-state logic for the fold FSM, accumulator, counter and output slot.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q & ~take;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        acc_next    = acc_q ^ f;
        cnt_next    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (mode_eff == MODE_FOLD && !in_last) begin
                    acc_d   = f;
                    cnt_d   = CNT_ONE;
                    state_d = ST_ACC;
                end else begin
                    out_data_d  = f;
                    out_count_d = CNT_ONE;
                    out_valid_d = 1'b1;
                end
            end else if (in_last) begin
                out_data_d  = acc_next;
                out_count_d = cnt_next;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = ST_IDLE;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_next;
            end
        end
    end

    // State and output registers; reset discards any partial fold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_speck_xor_unit.sv
// Bench for speck_xor_unit: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_speck_xor_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  mode;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in0, in1;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    logic [1:0]  s_mode;
    logic        s_in_valid, s_in_last, s_out_ready;
    logic [15:0] s_in0, s_in1;
    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [1:0]  s_out_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    speck_xor_unit #(.WIDTH(16), .ROT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    speck_xor_unit #(.WIDTH(16), .ROT(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .mode(s_mode), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in0(s_in0), .in1(s_in1), .in_last(s_in_last), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .out_count(s_out_count)
    );

    function automatic logic [15:0] rol16(input logic [15:0] x, input int r);
        return (r == 0) ? x : ((x << r) | (x >> (16 - r)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic last);
        in_valid = 1'b1;
        mode     = m;
        in0      = a;
        in1      = b;
        in_last  = last;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 2'd0; in_valid = 1'b0; in0 = '0; in1 = '0; in_last = 1'b0; out_ready = 1'b0;
        s_mode = 2'd2; s_in_valid = 1'b0; s_in0 = '0; s_in1 = '0; s_in_last = 1'b0;
        s_out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_during got=%0b exp=1", in_ready); end
        repeat (2) tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        tests++; if (out_count !== 8'h0) begin fails++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        rst = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_after got=%0b exp=1", in_ready); end
    endtask

    task automatic test_xor();
        out_ready = 1'b1;
        drive(2'd0, 16'hA5A5, 16'h0FF0, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL xor_valid got=%0b exp=1", out_valid); end
        tests++; if (out_data !== 16'hAA55) begin fails++; $display("FAIL xor_data got=%h exp=aa55", out_data); end
        tests++; if (out_count !== 8'd1) begin fails++; $display("FAIL xor_count got=%0d exp=1", out_count); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL xor_taken got=%0b exp=0", out_valid); end
        // reserved mode behaves as XOR
        drive(2'd3, 16'h1234, 16'h00FF, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_data !== 16'h12CB) begin fails++; $display("FAIL rsvd_data got=%h exp=12cb", out_data); end
        idle();
    endtask

    task automatic test_rolxor();
        out_ready = 1'b1;
        drive(2'd1, 16'h1234, 16'h8001, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_data !== 16'h1232) begin fails++; $display("FAIL rolxor_data got=%h exp=1232", out_data); end
        tests++; if (out_count !== 8'd1) begin fails++; $display("FAIL rolxor_count got=%0d exp=1", out_count); end
        idle();
    endtask

    task automatic test_fold();
        out_ready = 1'b1;
        drive(2'd2, 16'h0001, 16'h0002, 1'b0);
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fold_beat1_valid got=%0b exp=0", out_valid); end
        // mode is ignored once a fold is running
        drive(2'd1, 16'h0004, 16'h0008, 1'b0);
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fold_beat2_valid got=%0b exp=0", out_valid); end
        drive(2'd0, 16'h0010, 16'h0020, 1'b1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fold_valid got=%0b exp=1", out_valid); end
        tests++; if (out_data !== 16'h003F) begin fails++; $display("FAIL fold_data got=%h exp=003f", out_data); end
        tests++; if (out_count !== 8'd3) begin fails++; $display("FAIL fold_count got=%0d exp=3", out_count); end
        // single-beat fold
        drive(2'd2, 16'h5000, 16'h0005, 1'b1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (out_data !== 16'h5005 || out_count !== 8'd1) begin fails++; $display("FAIL fold_single got=%h/%0d exp=5005/1", out_data, out_count); end
        idle();
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b, c, d;
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
        out_ready = 1'b0;
        drive(2'd0, a, b, 1'b0);
        tick();
        drive(2'd0, c, d, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
            tests++; if (out_valid !== 1'b1 || out_data !== (a ^ b)) begin fails++; $display("FAIL bp_hold[%0d] got=%0b/%h exp=1/%h", i, out_valid, out_data, a ^ b); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_data !== (c ^ d)) begin fails++; $display("FAIL bp_load_take got=%0b/%h exp=1/%h", out_valid, out_data, c ^ d); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_fold();
        out_ready = 1'b1;
        drive(2'd2, 16'h1111, 16'h2222, 1'b0);
        tick();
        drive(2'd2, 16'h4444, 16'h8888, 1'b0);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 8'h0) begin fails++; $display("FAIL midfold_reset got=%0b/%h/%0d exp=0/0000/0", out_valid, out_data, out_count); end
        #1;
        rst = 1'b0;
        drive(2'd0, 16'h00FF, 16'h0F0F, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_data !== 16'h0FF0 || out_count !== 8'd1) begin fails++; $display("FAIL midfold_after got=%0b/%h/%0d exp=1/0ff0/1", out_valid, out_data, out_count); end
        idle();
    endtask

    task automatic test_saturation();
        s_out_ready = 1'b1;
        s_mode = 2'd2; s_in0 = 16'h0001; s_in1 = 16'h0000; s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_in_last = (i == 4);
            tick();
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        tests++; if (s_out_valid !== 1'b1 || s_out_data !== 16'h0001 || s_out_count !== 2'd3) begin fails++; $display("FAIL sat_result got=%0b/%h/%0d exp=1/0001/3", s_out_valid, s_out_data, s_out_count); end
        tick();
    endtask

    // Randomized traffic against a transaction-level model.
    task automatic test_random();
        logic        m_valid, m_fold;
        logic [15:0] m_data, f, r;
        int          m_count;
        logic [15:0] beats[$];
        logic        exp_ready, acc, take;

        rst = 1'b1; #1; rst = 1'b0;
        m_valid = 1'b0; m_fold = 1'b0; m_data = '0; m_count = 0;
        beats.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            mode      = 2'($urandom_range(0, 3));
            in0       = 16'($urandom);
            in1       = 16'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            #1;
            exp_ready = !m_valid || out_ready;
            tests++; if (in_ready !== exp_ready) begin fails++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ready); end
            acc  = in_valid && exp_ready;
            take = m_valid && out_ready;
            if (take) m_valid = 1'b0;
            if (acc) begin
                f = (!m_fold && mode == 2'd1) ? (in0 ^ rol16(in1, 2)) : (in0 ^ in1);
                if (m_fold || (mode == 2'd2 && !in_last)) begin
                    beats.push_back(f);
                    m_fold = 1'b1;
                    if (in_last) begin
                        r = '0;
                        foreach (beats[k]) r ^= beats[k];
                        m_data  = r;
                        m_count = (beats.size() > 255) ? 255 : beats.size();
                        m_valid = 1'b1;
                        m_fold  = 1'b0;
                        beats.delete();
                    end
                end else begin
                    m_data = f; m_count = 1; m_valid = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            tests++; if (out_valid !== m_valid) begin fails++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, m_valid); end
            if (m_valid) begin
                tests++; if (out_data !== m_data || out_count !== 8'(m_count)) begin fails++; $display("FAIL rnd_result cyc=%0d got=%h/%0d exp=%h/%0d", cyc, out_data, out_count, m_data, m_count); end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_xor();
        test_rolxor();
        test_fold();
        test_backpressure();
        test_reset_mid_fold();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
